integer_alu_axis_driver: RTL
============================

// Module: integer_alu_axis_driver
// PURPOSE
// - Stream-side counterpart of the integer_alu kernel: AXIS master for in1/in2/op, AXIS slave for out_r.
// - Turns one command per handshake into three operand beats and returns each result beat on a response handshake.
// - Built-in watchdog flags a stalled exchange and names the ports waiting on the kernel, in the same bit order the deadlock monitor uses.
// PARAMETERS
// - DATA_W       32    width of in1/in2/out_r TDATA
// - OP_W         32    width of op TDATA
// - MAX_OUTST    4     max operand sets issued with no result yet (1..15)
// - STALL_LIMIT  1024  idle-with-work cycles before stall is raised (>=2)
// PORTS
// - ap_clk        in   1         clock
// - ap_rst_n      in   1         synchronous active-low reset
// - cmd_valid     in   1         command present
// - cmd_ready     out  1         command accepted when valid&ready
// - cmd_in1       in   DATA_W    operand 1
// - cmd_in2       in   DATA_W    operand 2
// - cmd_op        in   OP_W      opcode
// - in1_TDATA/in1_TVALID/in1_TREADY  out/out/in  DATA_W/1/1   kernel operand 1
// - in2_TDATA/in2_TVALID/in2_TREADY  out/out/in  DATA_W/1/1   kernel operand 2
// - op_TDATA/op_TVALID/op_TREADY     out/out/in  OP_W/1/1     kernel opcode
// - out_r_TDATA/out_r_TVALID/out_r_TREADY in/in/out DATA_W/1/1 kernel result
// - rsp_valid     out  1         result present
// - rsp_ready     in   1         result consumed when valid&ready
// - rsp_data      out  DATA_W    result
// - outstanding   out  4         sets issued, results pending
// - stall         out  1         watchdog fired
// - stall_vec     out  4         [0]in1 [1]in2 [2]op unaccepted; [3]out_r awaited
// - err_unexp     out  1         sticky: result arrived with outstanding==0
// BEHAVIOUR
// - Reset (ap_rst_n==0 at posedge): all TVALID, rsp_valid, stall, err_unexp = 0; stall_vec, outstanding = 0;
//   cmd_ready = 0 during reset, FSM=IDLE; TDATA/rsp_data don't-care. Reset mid-transfer drops beats silently.
// - FSM IDLE: cmd_ready = (outstanding < MAX_OUTST). cmd handshake -> latch operands, raise all three TVALID, go SEND.
// - FSM SEND: cmd_ready=0. Each port independent: TVALID held with stable TDATA until own TREADY; then drops, done bit set.
//   When final pending port handshakes (any may coincide) -> IDLE, outstanding+1 on that edge.
//   Min command spacing 2 cycles (cmd edge, all-accepted edge, next cmd edge).
// - Response: one-entry register. out_r_TREADY = !rsp_valid | rsp_ready (pass-through, full throughput).
//   out_r handshake loads rsp_data next cycle; outstanding-1 (saturate at 0, set err_unexp if it was 0).
// - Simultaneous issue-complete and out_r handshake: outstanding unchanged.
// - Watchdog: busy = (state==SEND) | (outstanding!=0). cnt clears on any of the four handshakes or !busy,
//   else +1 saturating at STALL_LIMIT. stall = (cnt==STALL_LIMIT). On the edge cnt reaches limit, stall_vec captures
//   {outstanding!=0 & !out_r_TVALID & out_r_TREADY, op_TVALID, in2_TVALID, in1_TVALID}; held until stall clears.
//   Stall caused only by rsp_ready low (out_r_TREADY=0) is NOT a kernel stall: cnt frozen while rsp_valid&!rsp_ready.
// - stall clears on the next handshake (cycle after); err_unexp cleared only by reset.
// - cmd_ready, TVALIDs, rsp_valid, stall all registered outputs; no combinational path cmd_valid->cmd_ready.
// STRUCTURE
// - Package integer_alu_axis_pkg: state enum {IDLE,SEND}, port-index localparams IN1=0,IN2=1,OP=2,OUT_R=3
//   (shared with the deadlock monitor diagnostics), DATA_W/OP_W defaults.
// - Sub-module axis_stall_watchdog (busy, activity, freeze, wait_vec[3:0] -> stall, stall_vec); rest inline.
// TESTING
// - Reset hold 3 cycles, all TREADY=1: cmd {5,7,ADD}; in1/in2/op beats on cycle 1 after cmd edge;
//   out_r=12 returned -> rsp_data=12, outstanding 0->1->0.
// - Skewed ready: in1_TREADY at +1, op at +3, in2 at +5 -> each TVALID drops after own handshake, data stable; IDLE after +5.
// - Back-pressure: out_r_TVALID held, rsp_ready=0 for 20 cycles, MAX_OUTST=4 -> cmd_ready=0 after 4 issues, no stall raised.
// - Kernel hang: STALL_LIMIT=16, in2_TREADY stuck 0 -> stall=1 at 16 idle cycles, stall_vec=4'b0010; in2_TREADY=1 -> stall clears.
// - Missing result: issue 1 set, out_r_TVALID never -> stall_vec=4'b1000; spurious out_r with outstanding 0 -> err_unexp=1.
// - Reset asserted during SEND with in1 accepted -> all outputs at reset values next edge; new cmd accepted after release.

Source files
------------

// File: rtl/integer_alu_axis_pkg.sv
// rtl/integer_alu_axis_pkg.sv - shared types and constants for the integer_alu stream driver
package integer_alu_axis_pkg;

   // Driver sequencing: wait for a command, or push the three operand beats
   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Port indices shared with the deadlock monitor diagnostics
   localparam int IN1   = 0;
   localparam int IN2   = 1;
   localparam int OP    = 2;
   localparam int OUT_R = 3;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_OP_W   = 32;

endpackage

// File: rtl/integer_alu_axis_driver_watchdog.sv
// rtl/integer_alu_axis_driver_watchdog.sv - idle-with-work counter that flags a stalled kernel exchange
module axis_stall_watchdog
   import integer_alu_axis_pkg::*;
#(
   parameter int STALL_LIMIT = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       busy_i,
   input  logic       activity_i,
   input  logic       freeze_i,
   input  logic [3:0] wait_vec_i,
   output logic       stall_o,
   output logic [3:0] stall_vec_o
);

   localparam int CNT_W = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STALL_LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall_q, stall_d;
   logic [3:0]       stall_vec_q, stall_vec_d;

   // Count idle cycles with work pending; downstream back-pressure only pauses the count
   always_comb begin
      cnt_d       = cnt_q;
      stall_vec_d = stall_vec_q;
      if (!busy_i || activity_i) begin
         cnt_d = '0;
      end else if (freeze_i) begin
         cnt_d = cnt_q;
      end else if (cnt_q != LIMIT_C) begin
         cnt_d = cnt_q + 1'b1;
      end
      stall_d = (cnt_d == LIMIT_C);
      // Snapshot which ports were waiting on the edge the limit is reached
      if (!stall_d) begin
         stall_vec_d = '0;
      end else if (!stall_q) begin
         stall_vec_d = wait_vec_i;
      end
   end

   // Watchdog state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         stall_q     <= 1'b0;
         stall_vec_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         stall_q     <= stall_d;
         stall_vec_q <= stall_vec_d;
      end
   end

   assign stall_o     = stall_q;
   assign stall_vec_o = stall_vec_q;

endmodule

// File: rtl/integer_alu_axis_driver.sv
// rtl/integer_alu_axis_driver.sv - command-to-AXIS operand issuer and result collector for integer_alu
module integer_alu_axis_driver
   import integer_alu_axis_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int OP_W        = DEF_OP_W,
   parameter int MAX_OUTST   = 4,
   parameter int STALL_LIMIT = 1024
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_in1,
   input  logic [DATA_W-1:0] cmd_in2,
   input  logic [OP_W-1:0]   cmd_op,
   output logic [DATA_W-1:0] in1_TDATA,
   output logic              in1_TVALID,
   input  logic              in1_TREADY,
   output logic [DATA_W-1:0] in2_TDATA,
   output logic              in2_TVALID,
   input  logic              in2_TREADY,
   output logic [OP_W-1:0]   op_TDATA,
   output logic              op_TVALID,
   input  logic              op_TREADY,
   input  logic [DATA_W-1:0] out_r_TDATA,
   input  logic              out_r_TVALID,
   output logic              out_r_TREADY,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        outstanding,
   output logic              stall,
   output logic [3:0]        stall_vec,
   output logic              err_unexp
);

   state_e            state_q, state_d;
   logic              in1_v_q, in1_v_d;
   logic              in2_v_q, in2_v_d;
   logic              op_v_q, op_v_d;
   logic [DATA_W-1:0] in1_data_q, in1_data_d;
   logic [DATA_W-1:0] in2_data_q, in2_data_d;
   logic [OP_W-1:0]   op_data_q, op_data_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic [3:0]        outst_q, outst_d;
   logic              err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              issue;
   logic              cmd_hs;
   logic              rsp_hs;
   logic              kernel_activity;
   logic              busy;
   logic [3:0]        wait_vec;

   assign cmd_hs       = cmd_valid & cmd_ready_q;
   assign out_r_TREADY = !rsp_valid_q | rsp_ready;
   assign rsp_hs       = out_r_TVALID & out_r_TREADY;

   // Issue FSM: latch a command, then retire each operand port on its own handshake
   always_comb begin
      state_d    = state_q;
      in1_v_d    = in1_v_q;
      in2_v_d    = in2_v_q;
      op_v_d     = op_v_q;
      in1_data_d = in1_data_q;
      in2_data_d = in2_data_q;
      op_data_d  = op_data_q;
      issue      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               in1_data_d = cmd_in1;
               in2_data_d = cmd_in2;
               op_data_d  = cmd_op;
               in1_v_d    = 1'b1;
               in2_v_d    = 1'b1;
               op_v_d     = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (in1_TREADY) in1_v_d = 1'b0;
            if (in2_TREADY) in2_v_d = 1'b0;
            if (op_TREADY)  op_v_d  = 1'b0;
            if (!in1_v_d && !in2_v_d && !op_v_d) begin
               state_d = IDLE;
               issue   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outstanding count, unexpected-result flag, response register and registered cmd_ready
   always_comb begin
      outst_d     = outst_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (issue && !rsp_hs) begin
         outst_d = outst_q + 1'b1;
      end else if (!issue && rsp_hs) begin
         if (outst_q == 4'd0) err_d = 1'b1;
         else                 outst_d = outst_q - 1'b1;
      end
      if (rsp_hs) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = out_r_TDATA;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      cmd_ready_d = (state_d == IDLE) && (outst_d < 4'(MAX_OUTST));
   end

   // Control state register; beats in flight are dropped on reset
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q     <= IDLE;
         in1_v_q     <= 1'b0;
         in2_v_q     <= 1'b0;
         op_v_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         outst_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in1_v_q     <= in1_v_d;
         in2_v_q     <= in2_v_d;
         op_v_q      <= op_v_d;
         cmd_ready_q <= cmd_ready_d;
         outst_q     <= outst_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Payload registers carry no reset; they are qualified by the valid flags
   always_ff @(posedge ap_clk) begin
      in1_data_q <= in1_data_d;
      in2_data_q <= in2_data_d;
      op_data_q  <= op_data_d;
      rsp_data_q <= rsp_data_d;
   end

   assign kernel_activity = (in1_v_q & in1_TREADY) | (in2_v_q & in2_TREADY)
                          | (op_v_q & op_TREADY) | rsp_hs;
   assign busy            = (state_q == SEND) | (outst_q != 4'd0);

   always_comb begin
      wait_vec        = '0;
      wait_vec[IN1]   = in1_v_q;
      wait_vec[IN2]   = in2_v_q;
      wait_vec[OP]    = op_v_q;
      wait_vec[OUT_R] = (outst_q != 4'd0) & !out_r_TVALID & out_r_TREADY;
   end

   axis_stall_watchdog #(
      .STALL_LIMIT (STALL_LIMIT)
   ) u_watchdog (
      .clk_i       (ap_clk),
      .rst_ni      (ap_rst_n),
      .busy_i      (busy),
      .activity_i  (kernel_activity),
      .freeze_i    (rsp_valid_q & !rsp_ready),
      .wait_vec_i  (wait_vec),
      .stall_o     (stall),
      .stall_vec_o (stall_vec)
   );

   assign cmd_ready   = cmd_ready_q;
   assign in1_TDATA   = in1_data_q;
   assign in1_TVALID  = in1_v_q;
   assign in2_TDATA   = in2_data_q;
   assign in2_TVALID  = in2_v_q;
   assign op_TDATA    = op_data_q;
   assign op_TVALID   = op_v_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign outstanding = outst_q;
   assign err_unexp   = err_q;

endmodule
